shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, sets operand width; legal range 4..32.
REQ-002 Parameter SIGNED_EN, default 1; when 0, signed_mode is ignored and all operations are unsigned.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 multiplicand  input  WIDTH  operand A; sampled with start.
REQ-008 multiplier  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high in CALC and DONE.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 product  output  2*WIDTH  last completed result, held until the next completion.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 at an edge SHALL capture operands, latch the sign of the result (signed mode: sign(A) XOR sign(B); else 0), load |A| zero-extended to 2*WIDTH into the shift-left register, load |B| into the shift-right register, clear the accumulator and counter, and go to CALC.
REQ-014 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), held as unsigned WIDTH bits, with no overflow.
REQ-015 Each CALC cycle SHALL add the shift-left register to the accumulator when shift-right bit 0 is 1, shift left by 1, shift right by 1, and increment the counter.
REQ-016 CALC SHALL exit to DONE after the cycle in which the post-shift multiplier is zero (early termination) or the counter reaches WIDTH-1, whichever comes first.
REQ-017 CALC cycles SHALL equal (index of highest set bit of |B|)+1, minimum 1 (B=0 costs one cycle), maximum WIDTH.
REQ-018 Entering DONE SHALL load product with the accumulator, two's-complement negated in 2*WIDTH bits when the latched sign is 1; ready=1 for exactly the DONE cycle; DONE then returns to IDLE.
REQ-019 Latency SHALL be N+1 cycles from the accepting edge to ready high, where N is the CALC count; the worst case is WIDTH+1.
REQ-020 start in CALC or DONE SHALL be ignored, with no queueing; start held high in IDLE after DONE SHALL begin a new operation on the next edge.
REQ-021 Input changes after the accepting edge SHALL NOT affect the running result.
REQ-022 product SHALL change only on DONE entry; ready SHALL never assert twice per operation.
REQ-023 The result SHALL be exact for all operand pairs, with no truncation in 2*WIDTH bits.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE; product, accumulator, shift registers and counter to 0; ready=0; busy=0.
REQ-025 Reset during CALC or DONE SHALL abort the operation with no ready pulse; product reads 0 after reset.
REQ-026 The first accepting edge after reset release SHALL behave as REQ-013.

Structure
REQ-027 Package multiplier_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-028 Sub-module shift_add_datapath SHALL contain the shift-left register, shift-right register, accumulator/adder and zero-gating mux; the FSM, counter and sign logic stay in the top level.
REQ-029 Counter width SHALL be $clog2(WIDTH)+1 bits.

Verification
REQ-030 WIDTH=8, unsigned, A=200, B=255 -> ready pulses 9 cycles after the accepting edge; product=51000 (0xC738).
REQ-031 WIDTH=8, signed, A=-128, B=-128 -> product=16384 (0x4000); A=-7, B=5 -> product=0xFFDD (-35), 4 cycles latency.
REQ-032 B=0, A=0xFF -> one CALC cycle, ready 2 cycles after the accepting edge, product=0; B=1 -> latency 2, product=A.
REQ-033 start re-pulsed during CALC with new operands -> ignored; the original result is delivered and busy falls after DONE.
REQ-034 reset asserted mid-CALC -> busy, ready and product go to 0 immediately; no ready pulse follows.
REQ-035 WIDTH=16, signed_mode=1 with SIGNED_EN=0, A=0xFFFF, B=0xFFFF -> unsigned product 0xFFFE0001 after 17 cycles.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-and-add datapath: the multiplicand shifts left, the multiplier shifts
// right, and a gated adder accumulates partial products.
module shift_add_datapath
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic                 shift_done
);

  logic [2*WIDTH-1:0] shift_left_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   shift_right_reg;
  logic [WIDTH-1:0]   shift_right_next;

  // The low multiplier bit gates whether this cycle contributes a partial product.
  assign addend           = shift_right_reg[0] ? shift_left_reg : '0;
  assign acc_next         = acc_reg + addend;
  assign shift_right_next = shift_right_reg >> 1;
  assign shift_done       = (shift_right_next == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_left_reg  <= '0;
      shift_right_reg <= '0;
      acc_reg         <= '0;
    end else if (load) begin
      shift_left_reg  <= {{WIDTH{1'b0}}, a_mag};
      shift_right_reg <= b_mag;
      acc_reg         <= '0;
    end else if (step) begin
      shift_left_reg  <= shift_left_reg << 1;
      shift_right_reg <= shift_right_next;
      acc_reg         <= acc_next;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier with optional signed operands; the FSM,
// iteration counter and result sign live here, arithmetic in the datapath.
module shift_add_multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   LAST_COUNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W      = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W     = (2*WIDTH)'(1);

  state_t             state, next_state;
  logic [CNT_W-1:0]   count;
  logic               result_neg;
  logic               signed_eff;
  logic               load, step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_next;
  logic               shift_done;

  // Two's-complement magnitude; -2^(WIDTH-1) maps cleanly onto unsigned 2^(WIDTH-1).
  assign signed_eff = SIGNED_EN && signed_mode;
  assign a_mag = (signed_eff && multiplicand[WIDTH-1]) ? (~multiplicand + ONE_W) : multiplicand;
  assign b_mag = (signed_eff && multiplier[WIDTH-1])   ? (~multiplier + ONE_W)   : multiplier;

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);

  shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .acc_next   (acc_next),
    .shift_done (shift_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (shift_done || count == LAST_COUNT) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      result_neg <= 1'b0;
    end else if (load) begin
      count      <= '0;
      result_neg <= signed_eff && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end else if (step) begin
      count      <= count + 1'b1;
    end
  end

  // The final accumulation is captured straight from the adder on the way into DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product <= '0;
    end else if (state == CALC && next_state == DONE) begin
      product <= result_neg ? (~acc_next + ONE_2W) : acc_next;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: an 8-bit signed-capable instance
// and a 16-bit instance built with SIGNED_EN=0.
module tb_shift_add_multiplier;

  typedef struct {
    logic [31:0] prod;
    int          accept_cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q8[$];
  exp_t        q16[$];

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, ready8;
  logic [15:0] product8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, ready16;
  logic [31:0] product16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .ready(ready8), .product(product8)
  );

  shift_add_multiplier #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
    .clk(clk), .reset(rst_n), .start(start16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16),
    .busy(busy16), .ready(ready16), .product(product16)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Latency is counted in edges: the accepting edge is 0, and the edge that
  // samples ready high (the one ending the DONE cycle) is the latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready8) begin
      if (q8.size() == 0) begin
        checkOutput("dut8 unexpected ready", {63'd0, ready8}, 64'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("dut8 product", {48'd0, product8}, {32'd0, e.prod});
        checkOutput("dut8 latency", 64'(cyc - e.accept_cyc + 1), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready16) begin
      if (q16.size() == 0) begin
        checkOutput("dut16 unexpected ready", {63'd0, ready16}, 64'd0);
      end else begin
        e = q16.pop_front();
        checkOutput("dut16 product", {32'd0, product16}, {32'd0, e.prod});
        checkOutput("dut16 latency", 64'(cyc - e.accept_cyc + 1), 64'(e.lat));
      end
    end
  end

  task automatic waitIdle(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while (((sel == 0) ? busy8 : busy16) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL idle wait dut%0d actual=busy required=idle within 100 cycles", sel);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] b,
                               input logic sm, input logic [31:0] exp_prod, input int lat);
    exp_t e;
    waitIdle(sel);
    e.prod       = exp_prod;
    e.accept_cyc = cyc + 1;
    e.lat        = lat;
    if (sel == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; start8 = 1'b1;
      q8.push_back(e);
    end else begin
      a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
      q16.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    // Scramble operands after acceptance; the running result must not notice.
    a8 = ~a8; b8 = 8'h00; sm8 = ~sm8;
    a16 = ~a16; b16 = 16'h0000;
  endtask

  initial begin
    exp_t e;
    #12;
    checkOutput("reset busy8", {63'd0, busy8}, 64'd0);
    checkOutput("reset ready8", {63'd0, ready8}, 64'd0);
    checkOutput("reset product8", {48'd0, product8}, 64'd0);
    checkOutput("reset product16", {32'd0, product16}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First operation after reset release, then the documented vectors.
    applyStimulus(0, 16'd200, 16'd255, 1'b0, 32'h0000_C738, 9);
    applyStimulus(0, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000, 9);
    applyStimulus(0, 16'h00F9, 16'h0005, 1'b1, 32'h0000_FFDD, 4);
    applyStimulus(0, 16'h00FF, 16'h0000, 1'b0, 32'h0000_0000, 2);
    applyStimulus(0, 16'h00AB, 16'h0001, 1'b0, 32'h0000_00AB, 2);
    applyStimulus(0, 16'h0064, 16'h00FD, 1'b1, 32'h0000_FED4, 3);
    applyStimulus(0, 16'h00FF, 16'h0000, 1'b1, 32'h0000_0000, 2);
    applyStimulus(0, 16'h007F, 16'h007F, 1'b1, 32'h0000_3F01, 8);
    applyStimulus(0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01, 9);
    applyStimulus(0, 16'h0080, 16'h007F, 1'b1, 32'h0000_C080, 8);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 17);
    applyStimulus(1, 16'h8000, 16'h0002, 1'b1, 32'h0001_0000, 3);

    // start re-pulsed mid-CALC with new operands must be ignored.
    applyStimulus(0, 16'd200, 16'd255, 1'b0, 32'h0000_C738, 9);
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitIdle(0);
    repeat (3) @(negedge clk);
    checkOutput("product held", {48'd0, product8}, 64'h0000_C738);
    checkOutput("busy after done", {63'd0, busy8}, 64'd0);

    // start held high: 12*10 takes 4 CALC cycles, then the next accept
    // lands one edge after DONE returns to IDLE.
    waitIdle(0);
    a8 = 8'd12; b8 = 8'd10; sm8 = 1'b0; start8 = 1'b1;
    e.prod = 32'h0000_0078; e.accept_cyc = cyc + 1; e.lat = 5;
    q8.push_back(e);
    e.accept_cyc = cyc + 7;
    q8.push_back(e);
    repeat (7) @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    waitIdle(0);

    // Reset mid-CALC aborts with no ready and clears the product at once.
    a8 = 8'd200; b8 = 8'd255; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy8", {63'd0, busy8}, 64'd0);
    checkOutput("abort ready8", {63'd0, ready8}, 64'd0);
    checkOutput("abort product8", {48'd0, product8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("product after abort", {48'd0, product8}, 64'd0);

    applyStimulus(0, 16'h00F9, 16'h0005, 1'b1, 32'h0000_FFDD, 4);
    waitIdle(0);
    waitIdle(1);
    repeat (2) @(negedge clk);
    checkOutput("dut8 queue drained", 64'(q8.size()), 64'd0);
    checkOutput("dut16 queue drained", 64'(q16.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
